bist_resp_analyzer: RTL

BIST_RESP_ANALYZER -- requirements
Module: bist_resp_analyzer

---
 rtl/bist_resp_analyzer_pkg.sv | 18 +
 rtl/misr16.sv | 31 +++
 rtl/bist_resp_analyzer.sv | 86 ++++++++
 3 files changed

// File: rtl/bist_resp_analyzer_pkg.sv
// Shared definitions for the BIST response analyzer: FSM states, widths and
// the MISR feedback polynomial.
package bist_resp_analyzer_pkg;

    localparam int unsigned SigW  = 16;
    localparam int unsigned ByteW = 8;

    localparam logic [SigW-1:0]  MisrPoly = 16'h1021;
    localparam logic [ByteW-1:0] CntMax   = 8'hFF;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCompact = 2'd1,
        StCheck   = 2'd2,
        StReport  = 2'd3
    } state_e;

endpackage

// File: rtl/misr16.sv
// 16-bit multiple-input signature register: load folds the first byte into the
// seed, enable shifts with polynomial feedback and folds in the next byte.
module misr16
    import bist_resp_analyzer_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             enable,
    input  logic             load,
    input  logic [SigW-1:0]  seed,
    input  logic [ByteW-1:0] data,
    output logic [SigW-1:0]  sig
);

    logic [SigW-1:0] data_ext;
    logic [SigW-1:0] feedback;

    assign data_ext = {{(SigW - ByteW){1'b0}}, data};
    assign feedback = sig[SigW-1] ? MisrPoly : '0;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sig <= '0;
        end else if (load) begin
            sig <= seed ^ data_ext;
        end else if (enable) begin
            sig <= {sig[SigW-2:0], 1'b0} ^ feedback ^ data_ext;
        end
    end

endmodule

// File: rtl/bist_resp_analyzer.sv
// BIST response analyzer: compacts RESP into a MISR while RUNNING is high, then
// compares signature and cycle count with the expected values and holds a report.
module bist_resp_analyzer
    import bist_resp_analyzer_pkg::*;
#(
    parameter logic [SigW-1:0]  SEED       = 16'h0000,
    parameter logic [SigW-1:0]  GOLDEN     = 16'h0000,
    parameter logic [ByteW-1:0] EXP_CYCLES = 8'd90
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             RUNNING,
    input  logic [ByteW-1:0] RESP,
    input  logic             ACK,
    output logic [SigW-1:0]  SIGNATURE,
    output logic [ByteW-1:0] CYCLES,
    output logic             DONE,
    output logic             PASS
);

    state_e           state_q;
    logic [ByteW-1:0] cycles_q;
    logic             done_q;
    logic             pass_q;
    logic [SigW-1:0]  sig;
    logic             misr_load;
    logic             misr_en;

    assign misr_load = (state_q == StIdle) && RUNNING;
    assign misr_en   = (state_q == StCompact) && RUNNING;

    misr16 u_misr (
        .CLK    (CLK),
        .RESET  (RESET),
        .enable (misr_en),
        .load   (misr_load),
        .seed   (SEED),
        .data   (RESP),
        .sig    (sig)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= StIdle;
            cycles_q <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (RUNNING) begin
                        cycles_q <= 8'd1;
                        state_q  <= StCompact;
                    end
                end
                StCompact: begin
                    if (RUNNING) begin
                        cycles_q <= (cycles_q == CntMax) ? CntMax : cycles_q + 8'd1;
                    end else begin
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    pass_q  <= (sig == GOLDEN) && (cycles_q == EXP_CYCLES);
                    done_q  <= 1'b1;
                    state_q <= StReport;
                end
                StReport: begin
                    // Signature and count stay readable after the report is released.
                    if (ACK) begin
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign SIGNATURE = sig;
    assign CYCLES    = cycles_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;

endmodule
